// File: rtl/sipo_deser.sv
// Serial-in/parallel-out deserializer with a one-entry valid/ready output
// register, frame resync, busy indication and a sticky overflow flag.
//
// Handshake: a word moves to the consumer on any edge where pvalid && pready.
// pvalid, once set, stays high and pout stays stable until that transfer.
// pready is ignored while pvalid is low.
module sipo_deser #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sin,
  input  logic             sin_en,
  input  logic             sync,
  output logic [WIDTH-1:0] pout,
  output logic             pvalid,
  input  logic             pready,
  output logic             busy,
  output logic             ovf,
  input  logic             ovf_clr
);

  localparam int CW = (WIDTH <= 2) ? 1 : $clog2(WIDTH);

  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] pout_q, pout_d;
  logic             pvalid_q, pvalid_d;
  logic             ovf_q, ovf_d;

  logic [WIDTH-1:0] base_w;
  logic [WIDTH-1:0] shifted_w;
  logic             complete_w;

  // Shift register and bit counter; sync restarts the frame, and a bit
  // arriving with sync becomes the first bit of the new word.
  always_comb begin
    sr_d       = sr_q;
    cnt_d      = cnt_q;
    complete_w = 1'b0;
    base_w     = sync ? '0 : sr_q;
    if (MSB_FIRST) begin
      shifted_w = {base_w[WIDTH-2:0], sin};
    end else begin
      shifted_w = {sin, base_w[WIDTH-1:1]};
    end
    if (sin_en) begin
      sr_d = shifted_w;
      if (sync) begin
        cnt_d = CW'(1);
      end else if (cnt_q == CW'(WIDTH - 1)) begin
        cnt_d      = '0;
        complete_w = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end else if (sync) begin
      sr_d  = '0;
      cnt_d = '0;
    end
  end

  // Output register: load on completion if the slot is free or draining,
  // drop and flag overflow if it is held, otherwise retire on transfer.
  always_comb begin
    pout_d   = pout_q;
    pvalid_d = pvalid_q;
    ovf_d    = ovf_q;
    if (ovf_clr) begin
      ovf_d = 1'b0;
    end
    if (complete_w) begin
      if (!pvalid_q || pready) begin
        pout_d   = shifted_w;
        pvalid_d = 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end else if (pvalid_q && pready) begin
      pvalid_d = 1'b0;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr_q     <= '0;
      cnt_q    <= '0;
      pout_q   <= '0;
      pvalid_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      sr_q     <= sr_d;
      cnt_q    <= cnt_d;
      pout_q   <= pout_d;
      pvalid_q <= pvalid_d;
      ovf_q    <= ovf_d;
    end
  end

  assign pout   = pout_q;
  assign pvalid = pvalid_q;
  assign ovf    = ovf_q;
  assign busy   = (cnt_q != '0);

endmodule
